scfifo_ctrl: RTL and testbench

SCFIFO_CTRL -- requirements
Module: scfifo_ctrl

---
 rtl/scfifo_ctrl.sv | 138 +++++++++++++
 tb/tb_scfifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scfifo_ctrl.sv
// scfifo_ctrl: controller for a single-clock FIFO built around an external
// synchronous RAM (1-cycle registered read). A 2-entry output buffer hides
// the RAM read latency so the FIFO streams one word per cycle.
module scfifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH+1:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr_in,
  output logic [DATA_WIDTH-1:0]   ram_data_in,
  output logic [ADDR_WIDTH-1:0]   ram_addr_out,
  input  logic [DATA_WIDTH-1:0]   ram_data_out
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;
  // RAM depth expressed in pointer width: MSB set, rest zero.
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Architectural state.
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  // Combinational helpers.
  logic [PW-1:0] ram_count_s;
  logic [1:0]    occ_s;
  logic [1:0]    kept_s;
  logic          wr_s;
  logic          pop_s;
  logic          fetch_s;

  // Handshakes and fetch decision, derived only from registered state and inputs.
  always_comb begin
    ram_count_s = wptr_q - rptr_q;
    in_ready    = !srst && !flush && (ram_count_s != DEPTH_P);
    out_valid   = (buf_count_q != 2'd0) && !srst && !flush;
    out_data    = buf0_q;
    wr_s        = in_valid && in_ready;
    pop_s       = out_valid && out_ready;
    // Buffered words plus the one possibly returning from RAM never exceed 2.
    occ_s       = buf_count_q + {1'b0, inflight_q};
    fetch_s     = !srst && !flush && (ram_count_s != {PW{1'b0}}) &&
                  ((occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s));
  end

  // RAM write/read port drive.
  always_comb begin
    ram_wr_en    = wr_s;
    ram_addr_in  = wptr_q[ADDR_WIDTH-1:0];
    ram_data_in  = in_data;
    ram_addr_out = rptr_q[ADDR_WIDTH-1:0];
  end

  // Occupancy and status flags; count covers RAM, the in-flight read and the buffer.
  always_comb begin
    count = {1'b0, ram_count_s}
          + {{(CW-1){1'b0}}, inflight_q}
          + {{(CW-2){1'b0}}, buf_count_q};
    empty = (count == {CW{1'b0}});
    full  = (ram_count_s == DEPTH_P);
  end

  // Next-state: pointer advance, read pipeline and output buffer shift/fill.
  always_comb begin
    wptr_d      = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_s};
    rptr_d      = rptr_q + {{ADDR_WIDTH{1'b0}}, fetch_s};
    inflight_d  = fetch_s;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    kept_s      = buf_count_q;
    buf_count_d = buf_count_q;

    // Retire the head first so a returning word lands in the correct slot.
    if (pop_s) begin
      buf0_d = buf1_q;
      kept_s = buf_count_q - 2'd1;
    end else begin
      kept_s = buf_count_q;
    end

    if (inflight_q) begin
      if (kept_s == 2'd0) begin
        buf0_d = ram_data_out;
      end else begin
        buf1_d = ram_data_out;
      end
      buf_count_d = kept_s + 2'd1;
    end else begin
      buf_count_d = kept_s;
    end

    // Flush empties everything and drops this cycle's write and fetch.
    if (flush) begin
      wptr_d      = {PW{1'b0}};
      rptr_d      = {PW{1'b0}};
      inflight_d  = 1'b0;
      buf_count_d = 2'd0;
    end else begin
      buf_count_d = buf_count_d;
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge aclk) begin
    if (srst) begin
      wptr_q      <= {PW{1'b0}};
      rptr_q      <= {PW{1'b0}};
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      buf0_q      <= {DATA_WIDTH{1'b0}};
      buf1_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

endmodule

// File: tb/tb_scfifo_ctrl.sv
// Testbench for scfifo_ctrl: directed scenarios plus a randomized run, all
// checked against a queue-based FIFO model and a simple RAM model.
module tb_scfifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 2;

  logic          aclk;
  logic          srst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr_in;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_addr_out;
  logic [DW-1:0] ram_data_out;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] q [$];

  int passed = 0;
  int total  = 0;

  scfifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .srst(srst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .ram_wr_en(ram_wr_en), .ram_addr_in(ram_addr_in), .ram_data_in(ram_data_in),
    .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Synchronous RAM with registered read data.
  always @(posedge aclk) begin
    if (ram_wr_en) mem[ram_addr_in] <= ram_data_in;
    ram_data_out <= mem[ram_addr_out];
  end

  // Drive inputs after the falling edge and let combinational outputs settle.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic rs);
    @(negedge aclk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    srst      = rs;
    #1;
  endtask

  // Commit the cycle at the rising edge and update the FIFO model.
  task automatic advance(output bit wr, output bit rd);
    logic [DW-1:0] d;
    bit clr;
    wr  = in_valid && in_ready;
    rd  = out_valid && out_ready;
    d   = in_data;
    clr = srst || flush;
    @(posedge aclk);
    if (clr) begin
      q.delete();
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (wr) q.push_back(d);
    end
  endtask

  task automatic do_reset();
    bit w, r;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    advance(w, r);
  endtask

  task automatic test_reset();
    bit w, r;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    advance(w, r);
    step(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (ram_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", ram_wr_en); else passed++;
    advance(w, r);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (count !== CW'(0)) $display("FAIL rel_count: got %0d want 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rel_empty: got %b want 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL rel_full: got %b want 0", full); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_single();
    bit w, r;
    do_reset();
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    advance(w, r);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: cycle %0d got %b want 0", i, out_valid); else passed++;
      total++; if (count !== CW'(1)) $display("FAIL single_count: cycle %0d got %0d want 1", i, count); else passed++;
      advance(w, r);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 8'hA5) $display("FAIL single_data: got %h want a5", out_data); else passed++;
    total++; if (count !== CW'(1)) $display("FAIL single_count_hold: got %0d want 1", count); else passed++;
    advance(w, r);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL single_valid_after: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_fill_drain();
    bit w, r;
    int got;
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      total++; if (in_ready !== 1'b1) $display("FAIL fill_in_ready: word %0d got %b want 1", i, in_ready); else passed++;
      advance(w, r);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      advance(w, r);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (count !== CW'(DEPTH + 2)) $display("FAIL fill_count: got %0d want %0d", count, DEPTH + 2); else passed++;
    total++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready_full: got %b want 0", in_ready); else passed++;
    got = 0;
    for (int c = 0; c < 4 * DEPTH && got < DEPTH + 2; c++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (out_valid === 1'b1) begin
        total++; if (out_data !== DW'(got)) $display("FAIL drain_data: index %0d got %h want %h", got, out_data, DW'(got)); else passed++;
        got++;
      end
      advance(w, r);
    end
    total++; if (got !== DEPTH + 2) $display("FAIL drain_words: got %0d want %0d", got, DEPTH + 2); else passed++;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else passed++;
  endtask

  task automatic test_back_to_back();
    bit w, r;
    bit started;
    int sent, got;
    do_reset();
    started = 1'b0; sent = 0; got = 0;
    for (int c = 0; c < 3 * DEPTH + 20 && got < 3 * DEPTH; c++) begin
      step(sent < 3 * DEPTH, DW'(sent * 7 + 3), 1'b1, 1'b0, 1'b0);
      if (sent < 3 * DEPTH) begin
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: cycle %0d got %b want 1", c, in_ready); else passed++;
      end
      if (started) begin
        total++; if (out_valid !== 1'b1) $display("FAIL b2b_bubble: cycle %0d got %b want 1", c, out_valid); else passed++;
      end
      if (out_valid === 1'b1) begin
        started = 1'b1;
        total++; if (out_data !== DW'(got * 7 + 3)) $display("FAIL b2b_data: index %0d got %h want %h", got, out_data, DW'(got * 7 + 3)); else passed++;
        got++;
      end
      advance(w, r);
      if (w) sent++;
    end
    total++; if (got !== 3 * DEPTH) $display("FAIL b2b_words: got %0d want %0d", got, 3 * DEPTH); else passed++;
  endtask

  task automatic test_random();
    bit w, r;
    int sent, cyc;
    do_reset();
    sent = 0; cyc = 0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      step((sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0, DW'($urandom),
           1'($urandom_range(0, 1)), 1'b0, 1'b0);
      total++; if (count !== CW'(q.size())) $display("FAIL rnd_count: cycle %0d got %0d want %0d", cyc, count, q.size()); else passed++;
      total++; if (empty !== (q.size() == 0)) $display("FAIL rnd_empty: cycle %0d got %b want %b", cyc, empty, q.size() == 0); else passed++;
      if (q.size() < DEPTH) begin
        total++; if (in_ready !== 1'b1) $display("FAIL rnd_in_ready: cycle %0d got %b want 1", cyc, in_ready); else passed++;
      end
      if (q.size() == DEPTH + 2) begin
        total++; if (in_ready !== 1'b0) $display("FAIL rnd_overfill: cycle %0d got %b want 0", cyc, in_ready); else passed++;
      end
      if (out_valid === 1'b1) begin
        total++;
        if (q.size() == 0) $display("FAIL rnd_spurious: cycle %0d got valid with model empty", cyc);
        else if (out_data !== q[0]) $display("FAIL rnd_data: cycle %0d got %h want %h", cyc, out_data, q[0]);
        else passed++;
      end
      advance(w, r);
      if (w) sent++;
      cyc++;
    end
    total++; if (cyc >= 60000) $display("FAIL rnd_timeout: got %0d cycles want below 60000", cyc); else passed++;
  endtask

  task automatic test_flush();
    bit w, r;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      advance(w, r);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      advance(w, r);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (out_data !== 8'h10) $display("FAIL flush_pre_data: got %h want 10", out_data); else passed++;
    advance(w, r);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    total++; if (count !== CW'(5)) $display("FAIL flush_pre_count: got %0d want 5", count); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else passed++;
    advance(w, r);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (count !== CW'(0)) $display("FAIL flush_count: got %0d want 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", empty); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_valid_after: got %b want 0", out_valid); else passed++;
    advance(w, r);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    advance(w, r);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      advance(w, r);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1) $display("FAIL flush_new_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 8'h3C) $display("FAIL flush_new_data: got %h want 3c", out_data); else passed++;
    advance(w, r);
  endtask

  task automatic test_srst_full();
    bit w, r;
    do_reset();
    for (int i = 0; i < DEPTH + 5; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      advance(w, r);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (full !== 1'b1) $display("FAIL srst_pre_full: got %b want 1", full); else passed++;
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    total++; if (in_ready !== 1'b0) $display("FAIL srst_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL srst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (ram_wr_en !== 1'b0) $display("FAIL srst_wr_en: got %b want 0", ram_wr_en); else passed++;
    advance(w, r);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (count !== CW'(0)) $display("FAIL srst_count: got %0d want 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL srst_empty: got %b want 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL srst_full: got %b want 0", full); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL srst_in_ready_after: got %b want 1", in_ready); else passed++;
  endtask

  initial begin
    srst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_srst_full();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
